// File: rtl/dma_bus_arbiter.sv
// dma_bus_arbiter: shares the board's single DMA channel among NREQ peripherals.
// Build option DMA_ARB_RR_EN selects round-robin arbitration; otherwise fixed priority, lowest index wins.
//
// state     | meaning
// ----------+------------------------------------------------------------
// S_IDLE    | no tenure; arbitrate pending requests
// S_REQ     | owner latched, dma_req raised, waiting for dma_ack
// S_GRANT   | owner holds the bus; address/strobe/ack routed to it
// S_RELEASE | dma_req and grant dropped, waiting for dma_ack to fall
module dma_bus_arbiter #(
    parameter int NREQ     = 4,
    parameter int MAXBURST = 16,
    parameter int OWN_W    = 3
) (
    input  logic                clk_p,
    input  logic                dclo_n,
    input  logic [NREQ-1:0]     dev_req,
    output logic [NREQ-1:0]     dev_gnt,
    input  logic [18*NREQ-1:0]  dev_adr18,
    input  logic [NREQ-1:0]     dev_stb,
    output logic [NREQ-1:0]     dev_ack,
    output logic                dma_req,
    input  logic                dma_ack,
    output logic [17:0]         dma_adr18,
    output logic                dma_stb,
    input  logic                global_ack,
    output logic [OWN_W-1:0]    owner,
    output logic                busy
);

    localparam int CNT_W = (MAXBURST > 0) ? $clog2(MAXBURST + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAXBURST);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_GRANT, S_RELEASE} state_t;

    state_t           r_state, w_next;
    logic [OWN_W-1:0] r_owner, w_arb_owner;
    logic [CNT_W-1:0] r_cnt;
    logic             r_dma_req;
    logic [NREQ-1:0]  r_gnt, w_own_mask;
    logic             w_own_req, w_own_stb, w_others, w_xfer, w_preempt;

    always_comb begin
        w_own_mask = '0;
        for (int i = 0; i < NREQ; i++)
            if (r_owner == OWN_W'(i)) w_own_mask[i] = 1'b1;
    end

    assign w_own_req = |(dev_req & w_own_mask);
    assign w_own_stb = |(dev_stb & w_own_mask);
    assign w_others  = |(dev_req & ~w_own_mask);
    assign w_preempt = (MAXBURST != 0) && (r_cnt == CNT_MAX) && w_others;

`ifdef DMA_ARB_RR_EN
    logic [OWN_W-1:0] r_rr_ptr;

    // Requester closest after the pointer (modulo NREQ) wins.
    always_comb begin
        int best;
        int dist;
        best        = NREQ;
        dist        = 0;
        w_arb_owner = '0;
        for (int i = 0; i < NREQ; i++) begin
            dist = (i + 2 * NREQ - int'(r_rr_ptr) - 1) % NREQ;
            if (dev_req[i] && dist < best) begin
                best        = dist;
                w_arb_owner = OWN_W'(i);
            end
        end
    end

    always_ff @(posedge clk_p or negedge dclo_n) begin
        if (!dclo_n)
            r_rr_ptr <= OWN_W'(NREQ - 1);
        else if (r_state == S_REQ && w_next == S_GRANT)
            r_rr_ptr <= r_owner;
    end
`else
    always_comb begin
        w_arb_owner = '0;
        for (int i = NREQ - 1; i >= 0; i--)
            if (dev_req[i]) w_arb_owner = OWN_W'(i);
    end
`endif

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:    if (|dev_req) w_next = S_REQ;
            S_REQ: begin
                if (!w_own_req)   w_next = S_RELEASE;
                else if (dma_ack) w_next = S_GRANT;
            end
            // A board error (dma_ack low) ends the tenure even mid-strobe.
            S_GRANT: begin
                if (!dma_ack)
                    w_next = S_RELEASE;
                else if (!w_own_stb && (!w_own_req || w_preempt))
                    w_next = S_RELEASE;
            end
            S_RELEASE: if (!dma_ack) w_next = S_IDLE;
            default:   w_next = S_IDLE;
        endcase
    end

    assign w_xfer = dma_stb & global_ack;

    always_ff @(posedge clk_p or negedge dclo_n) begin
        if (!dclo_n) begin
            r_state   <= S_IDLE;
            r_owner   <= '0;
            r_cnt     <= '0;
            r_dma_req <= 1'b0;
            r_gnt     <= '0;
        end else begin
            r_state   <= w_next;
            r_dma_req <= (w_next == S_REQ) || (w_next == S_GRANT);
            r_gnt     <= (w_next == S_GRANT) ? w_own_mask : '0;
            if (r_state == S_IDLE && w_next == S_REQ)
                r_owner <= w_arb_owner;
            if (r_state == S_REQ)
                r_cnt <= '0;
            else if (r_state == S_GRANT && w_xfer && r_cnt != CNT_MAX)
                r_cnt <= r_cnt + 1'b1;
        end
    end

    // r_gnt is one-hot or zero, so the mux collapses to zero outside a grant.
    always_comb begin
        dma_adr18 = '0;
        dma_stb   = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (r_gnt[i]) begin
                dma_adr18 = dev_adr18[18*i +: 18];
                dma_stb   = dev_stb[i];
            end
        end
    end

    assign dev_ack = r_gnt & {NREQ{global_ack & dma_stb}};
    assign dev_gnt = r_gnt;
    assign dma_req = r_dma_req;
    assign owner   = r_owner;
    assign busy    = (r_state != S_IDLE);

endmodule

// File: tb/tb_dma_bus_arbiter.sv
// Bench for dma_bus_arbiter (NREQ=4, MAXBURST=4); grant expectations follow DMA_ARB_RR_EN.
module tb_dma_bus_arbiter;

    logic        clk_p = 1'b0;
    logic        dclo_n;
    logic [3:0]  dev_req, dev_gnt, dev_stb, dev_ack;
    logic [71:0] dev_adr18;
    logic        dma_req, dma_ack, dma_stb, global_ack, busy;
    logic [17:0] dma_adr18;
    logic [2:0]  owner;

    int n_vec = 0;
    int n_err = 0;
    logic [3:0] exp_q[$];

    dma_bus_arbiter #(.NREQ(4), .MAXBURST(4), .OWN_W(3)) dut (
        .clk_p(clk_p), .dclo_n(dclo_n), .dev_req(dev_req), .dev_gnt(dev_gnt),
        .dev_adr18(dev_adr18), .dev_stb(dev_stb), .dev_ack(dev_ack),
        .dma_req(dma_req), .dma_ack(dma_ack), .dma_adr18(dma_adr18), .dma_stb(dma_stb),
        .global_ack(global_ack), .owner(owner), .busy(busy)
    );

    always #5 clk_p = ~clk_p;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Raise a request from IDLE, play the board's dma_ack, and pop the expected grant.
    task automatic acquire(input logic [3:0] req, input logic [3:0] exp_gnt);
        int k;
        logic [3:0] e;
        dev_req = req;
        exp_q.push_back(exp_gnt);
        k = 0;
        do begin @(negedge clk_p); k++; end while (!dma_req && k < 8);
        n_vec++; if (k !== 1) begin n_err++; $display("FAIL dma_req_latency: got %0d cycles, want 1", k); end
        dma_ack = 1'b1;
        k = 0;
        do begin @(negedge clk_p); k++; end while (dev_gnt == 4'b0 && k < 8);
        n_vec++; if (k !== 1) begin n_err++; $display("FAIL gnt_latency: got %0d cycles, want 1", k); end
        e = exp_q.pop_front();
        n_vec++; if (dev_gnt !== e) begin n_err++; $display("FAIL grant: dev_gnt=%b want %b", dev_gnt, e); end
    endtask

    task automatic release_bus();
        int k;
        dma_ack = 1'b0;
        k = 0;
        do begin @(negedge clk_p); k++; end while (busy && k < 8);
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL release_idle: busy=%b want 0", busy); end
    endtask

    task automatic xfer(input int n, input logic [3:0] oh);
        for (int c = 0; c < n; c++) begin
            dev_stb = oh;
            global_ack = 1'b1;
            @(negedge clk_p);
            n_vec++; if (dev_ack !== oh) begin n_err++; $display("FAIL dev_ack: got %b want %b", dev_ack, oh); end
        end
        global_ack = 1'b0;
    endtask

    task automatic test_reset();
        dclo_n = 1'b0; dev_req = 4'b0; dev_stb = 4'b1111; dma_ack = 1'b0; global_ack = 1'b1;
        dev_adr18 = {18'o777777, 18'o555555, 18'o222222, 18'o123456};
        #12;
        n_vec++; if (dma_req !== 1'b0) begin n_err++; $display("FAIL reset_dma_req: got %b want 0", dma_req); end
        n_vec++; if (dev_gnt !== 4'b0) begin n_err++; $display("FAIL reset_gnt: got %b want 0000", dev_gnt); end
        n_vec++; if ({owner, busy} !== 4'b0) begin n_err++; $display("FAIL reset_owner_busy: got %0d/%b want 0/0", owner, busy); end
        n_vec++; if ({dma_adr18, dma_stb, dev_ack} !== 23'b0) begin n_err++; $display("FAIL reset_comb: adr=%o stb=%b ack=%b want 0", dma_adr18, dma_stb, dev_ack); end
        dev_stb = 4'b0; global_ack = 1'b0;
        @(negedge clk_p);
        dclo_n = 1'b1;
        @(negedge clk_p);
    endtask

    task automatic test_single();
        acquire(4'b0001, 4'b0001);
        n_vec++; if ({busy, owner} !== 4'b1000) begin n_err++; $display("FAIL single_owner: busy=%b owner=%0d want 1/0", busy, owner); end
        dev_stb = 4'b0001;
        #1;
        n_vec++; if (dma_adr18 !== 18'o123456 || dma_stb !== 1'b1) begin n_err++; $display("FAIL single_adr: adr=%o stb=%b want 123456/1", dma_adr18, dma_stb); end
        @(negedge clk_p);
        xfer(3, 4'b0001);
        dev_stb = 4'b0; dev_req = 4'b0;
        @(negedge clk_p);
        n_vec++; if (dma_req !== 1'b0 || dev_gnt !== 4'b0) begin n_err++; $display("FAIL single_release: dma_req=%b gnt=%b want 0/0000", dma_req, dev_gnt); end
        release_bus();
    endtask

    task automatic test_simultaneous();
        logic [3:0] exp2;
`ifdef DMA_ARB_RR_EN
        exp2 = 4'b1000;
`else
        exp2 = 4'b0010;
`endif
        acquire(4'b1010, 4'b0010);
        xfer(4, 4'b0010);
        @(negedge clk_p);
        n_vec++; if (dev_gnt !== 4'b0010) begin n_err++; $display("FAIL no_cut: gnt=%b want 0010 while stb high", dev_gnt); end
        dev_stb = 4'b0;
        @(negedge clk_p);
        n_vec++; if (dma_req !== 1'b0 || dev_gnt !== 4'b0) begin n_err++; $display("FAIL preempt: dma_req=%b gnt=%b want 0/0000", dma_req, dev_gnt); end
        release_bus();
        acquire(4'b1010, exp2);
        dev_req = 4'b0;
        @(negedge clk_p);
        n_vec++; if (dma_req !== 1'b0) begin n_err++; $display("FAIL simul_drop: dma_req=%b want 0", dma_req); end
        release_bus();
    endtask

    task automatic test_maxburst();
        logic [3:0] exp2;
`ifdef DMA_ARB_RR_EN
        exp2 = 4'b0100;
`else
        exp2 = 4'b0001;
`endif
        acquire(4'b0001, 4'b0001);
        dev_req = 4'b0101;
        xfer(4, 4'b0001);
        dev_stb = 4'b0;
        @(negedge clk_p);
        n_vec++; if (dev_gnt !== 4'b0) begin n_err++; $display("FAIL burst_release: gnt=%b want 0000", dev_gnt); end
        release_bus();
        acquire(4'b0101, exp2);
        xfer(3, exp2);
        dev_stb = 4'b0;
        @(negedge clk_p);
        n_vec++; if (dev_gnt !== exp2) begin n_err++; $display("FAIL burst_cnt_clear: gnt=%b want %b", dev_gnt, exp2); end
        xfer(1, exp2);
        dev_stb = 4'b0;
        @(negedge clk_p);
        n_vec++; if (dev_gnt !== 4'b0) begin n_err++; $display("FAIL burst_second: gnt=%b want 0000", dev_gnt); end
        dev_req = 4'b0;
        release_bus();
    endtask

    task automatic test_withdraw();
        logic [3:0] seen;
        dev_req = 4'b0100;
        @(negedge clk_p);
        n_vec++; if (dma_req !== 1'b1 || owner !== 3'd2) begin n_err++; $display("FAIL withdraw_req: dma_req=%b owner=%0d want 1/2", dma_req, owner); end
        dev_req = 4'b0;
        seen = 4'b0;
        @(negedge clk_p);
        n_vec++; if (dma_req !== 1'b0) begin n_err++; $display("FAIL withdraw_drop: dma_req=%b want 0", dma_req); end
        for (int c = 0; c < 4; c++) begin
            seen = seen | dev_gnt;
            @(negedge clk_p);
        end
        n_vec++; if (seen !== 4'b0 || busy !== 1'b0) begin n_err++; $display("FAIL withdraw_gnt: seen=%b busy=%b want 0000/0", seen, busy); end
    endtask

    task automatic test_ack_drop();
        acquire(4'b0001, 4'b0001);
        dev_stb = 4'b0001;
        @(negedge clk_p);
        n_vec++; if (dma_stb !== 1'b1) begin n_err++; $display("FAIL err_stb: dma_stb=%b want 1", dma_stb); end
        dma_ack = 1'b0;
        @(negedge clk_p);
        n_vec++; if ({dev_gnt, dma_stb, dma_req, busy} !== 7'b0000001) begin n_err++; $display("FAIL err_release: gnt=%b stb=%b req=%b busy=%b want 0000/0/0/1", dev_gnt, dma_stb, dma_req, busy); end
        @(negedge clk_p);
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL err_idle: busy=%b want 0", busy); end
        dev_req = 4'b0; dev_stb = 4'b0;
        @(negedge clk_p);
    endtask

    task automatic test_reset_mid();
        acquire(4'b0010, 4'b0010);
        dev_stb = 4'b0010;
        @(negedge clk_p);
        #2 dclo_n = 1'b0;
        #1;
        n_vec++; if ({dma_req, dev_gnt, dma_stb} !== 6'b0) begin n_err++; $display("FAIL rst_mid_outs: req=%b gnt=%b stb=%b want 0", dma_req, dev_gnt, dma_stb); end
        n_vec++; if (busy !== 1'b0 || owner !== 3'd0) begin n_err++; $display("FAIL rst_mid_state: busy=%b owner=%0d want 0/0", busy, owner); end
        dev_req = 4'b0; dev_stb = 4'b0; dma_ack = 1'b0;
        @(negedge clk_p);
        dclo_n = 1'b1;
        @(negedge clk_p);
    endtask

    initial begin
        test_reset();
        test_single();
        test_simultaneous();
        test_maxburst();
        test_withdraw();
        test_ack_drop();
        test_reset_mid();
        n_vec++; if (exp_q.size() !== 0) begin n_err++; $display("FAIL scoreboard: %0d grants left, want 0", exp_q.size()); end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
